dmem_ctrl: RTL and testbench

- Parametrised data memory for the RV32/RV64 core's MEM stage, generalising the existing single-word memory.
- Adds byte-addressed LB/LH/LW/(LD) and SB/SH/SW/(SD) accesses with byte-lane writes.
- Adds load sign/zero extension and misalign/out-of-range error reporting.
- Adds a valid/ready request channel, a fixed-latency response and a post-reset clearing sequence.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 52 +++++
 rtl/dmem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the byte-enable helper for the data memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    // 2^size consecutive enabled bytes starting at the given lane (up to 8 lanes).
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] lane);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << lane;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data/byte-enables on the way in,
// load shift/mask/sign-extension on the way out.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF    = $clog2(NB)
) (
    input  logic [1:0]        st_size_i,
    input  logic [OFF-1:0]    st_lane_i,
    input  logic [DATA_W-1:0] st_wdata_i,
    output logic [NB-1:0]     st_be_o,
    output logic [DATA_W-1:0] st_data_o,

    input  logic [DATA_W-1:0] ld_word_i,
    input  logic [OFF-1:0]    ld_lane_i,
    input  logic [1:0]        ld_size_i,
    input  logic              ld_unsigned_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]        be_full;
    logic [DATA_W-1:0] shifted;
    logic              sign;
    int                nbits;

    assign be_full   = byte_en(st_size_i, 3'(st_lane_i));
    assign st_be_o   = be_full[NB-1:0];
    assign st_data_o = st_wdata_i << {st_lane_i, 3'b000};

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        ld_data_o = '0;
        shifted   = ld_word_i >> {ld_lane_i, 3'b000};
        nbits     = 8 << ld_size_i;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        case (ld_size_i)
            SZ_B:    sign = shifted[7];
            SZ_H:    sign = shifted[15];
            SZ_W:    sign = shifted[31];
            default: sign = shifted[DATA_W-1];
        endcase
        sign = sign & ~ld_unsigned_i;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data_o[i] = (i < nbits) ? shifted[i] : sign;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory for the MEM stage: post-reset clear, one request
// per cycle, fixed-latency in-order responses with error reporting.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 128,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter bit OUT_REG    = 1'b0,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = ADDR_W - OFF;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W:0]   DEPTH_X = (IDX_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               accept, req_err, misal, bad_size, out_range;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   widx;
    logic [OFF-1:0]     lane;
    logic [2:0]         align_mask;
    logic [NB-1:0]      st_be;
    logic [DATA_W-1:0]  st_data, ld_data;

    logic               s1_valid_q, s1_err_q, s1_we_q, s1_uns_q;
    logic [OFF-1:0]     s1_lane_q;
    logic [1:0]         s1_size_q;
    logic [DATA_W-1:0]  s1_word_q;
    logic               rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]  rsp_rdata_d;

    assign idx        = req_addr[ADDR_W-1:OFF];
    assign widx       = idx[CNT_W-1:0];
    assign lane       = req_addr[OFF-1:0];
    assign align_mask = (3'd1 << req_size) - 3'd1;
    assign misal      = |(3'(lane) & align_mask);
    assign bad_size   = (req_size == SZ_D) && (DATA_W != 64);
    assign out_range  = {1'b0, idx} >= DEPTH_X;
    assign req_err    = misal | bad_size | out_range;
    assign req_ready  = (state_q == ST_RUN);
    assign accept     = req_valid && req_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (!INIT_CLEAR || cnt_q == LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    dmem_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_size_i     (req_size),
        .st_lane_i     (lane),
        .st_wdata_i    (req_wdata),
        .st_be_o       (st_be),
        .st_data_o     (st_data),
        .ld_word_i     (s1_word_q),
        .ld_lane_i     (s1_lane_q),
        .ld_size_i     (s1_size_q),
        .ld_unsigned_i (s1_uns_q),
        .ld_data_o     (ld_data)
    );

    // NOTE: the array has no reset port; it is zeroed by the INIT walk instead.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_INIT && INIT_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (accept && req_we && !req_err) begin
            for (int b = 0; b < NB; b++) begin
                if (st_be[b]) begin
                    mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
    end

    // Payload travels beside s1_valid_q and is only looked at when it is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_err_q  <= req_err;
            s1_we_q   <= req_we;
            s1_uns_q  <= req_unsigned;
            s1_lane_q <= lane;
            s1_size_q <= req_size;
            s1_word_q <= mem_q[widx];
        end
    end

    assign rsp_valid_d = s1_valid_q;
    assign rsp_err_d   = s1_valid_q & s1_err_q;
    assign rsp_rdata_d = (s1_valid_q && !s1_err_q && !s1_we_q) ? ld_data : '0;

    if (OUT_REG) begin : g_out_reg
        logic              rsp_valid_q, rsp_err_q;
        logic [DATA_W-1:0] rsp_rdata_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end else begin
                rsp_valid_q <= rsp_valid_d;
                rsp_err_q   <= rsp_err_d;
                rsp_rdata_q <= rsp_rdata_d;
            end
        end
        assign rsp_valid = rsp_valid_q;
        assign rsp_err   = rsp_err_q;
        assign rsp_rdata = rsp_rdata_q;
    end else begin : g_out_comb
        assign rsp_valid = rsp_valid_d;
        assign rsp_err   = rsp_err_d;
        assign rsp_rdata = rsp_rdata_d;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Drives two dmem_ctrl instances (latency 1 and latency 2) with identical
// requests and checks both against hand-computed expectations.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready0, ready1, valid0, valid1, err0, err1;
    logic [31:0] rdata0, rdata1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    dmem_ctrl #(.OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0)
    );

    dmem_ctrl #(.OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [1:0] size, input logic uns,
                                input logic [15:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_err, input string name);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.name = name;
        vecs.push_back(v);
    endfunction

    // Called #1 after a rising edge; counts edges until both instances are ready.
    task automatic wait_init(input string name);
        int n = 0;
        int stray = 0;
        while (!(ready0 && ready1) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (valid0 || valid1) stray++;
        end
        check({name, "_cycles"}, 64'(n), 64'd128);
        check({name, "_stray_rsp"}, 64'(stray), 64'd0);
    endtask

    // One isolated request; dut0 answers after the accept edge, dut1 one edge later.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check({name, "_ready"}, {62'd0, ready1, ready0}, 64'd3);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({name, "_v0"}, 64'(valid0), 64'd1);
        check({name, "_d0"}, 64'(rdata0), 64'(exp_rd));
        check({name, "_e0"}, 64'(err0), 64'(exp_err));
        check({name, "_v1_early"}, 64'(valid1), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_v0_pulse"}, 64'(valid0), 64'd0);
        check({name, "_v1"}, 64'(valid1), 64'd1);
        check({name, "_d1"}, 64'(rdata1), 64'(exp_rd));
        check({name, "_e1"}, 64'(err1), 64'(exp_err));
    endtask

    logic        obs_v0 [10], obs_v1 [10];
    logic [31:0] obs_d0 [10], obs_d1 [10];
    logic [31:0] sdat   [4];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        add(0, SZ_W, 0, 16'h007C, 32'h0,        32'h0,        0, "lw_7c_cleared");
        add(1, SZ_W, 0, 16'h0010, 32'h8899AABB, 32'h0,        0, "sw_10");
        add(1, SZ_B, 0, 16'h0011, 32'h00000011, 32'h0,        0, "sb_11");
        add(1, SZ_H, 0, 16'h0012, 32'h00002233, 32'h0,        0, "sh_12");
        add(0, SZ_W, 0, 16'h0010, 32'h0,        32'h223311BB, 0, "lw_10_merge");
        add(1, SZ_W, 0, 16'h0010, 32'h80FF7F01, 32'h0,        0, "sw_10_pattern");
        add(0, SZ_B, 0, 16'h0012, 32'h0,        32'hFFFFFFFF, 0, "lb_12");
        add(0, SZ_B, 1, 16'h0012, 32'h0,        32'h000000FF, 0, "lbu_12");
        add(0, SZ_H, 0, 16'h0012, 32'h0,        32'hFFFF80FF, 0, "lh_12");
        add(0, SZ_H, 1, 16'h0012, 32'h0,        32'h000080FF, 0, "lhu_12");
        add(0, SZ_B, 0, 16'h0010, 32'h0,        32'h00000001, 0, "lb_10");
        add(0, SZ_B, 0, 16'h0011, 32'h0,        32'h0000007F, 0, "lb_11");
        add(0, SZ_H, 0, 16'h0010, 32'h0,        32'h00007F01, 0, "lh_10");
        add(0, SZ_B, 1, 16'h0013, 32'h0,        32'h00000080, 0, "lbu_13");
        add(0, SZ_W, 1, 16'h0010, 32'h0,        32'h80FF7F01, 0, "lw_10_uflag");
        add(1, SZ_B, 0, 16'h0013, 32'hCCDDEEAB, 32'h0,        0, "sb_13_upper");
        add(0, SZ_W, 0, 16'h0010, 32'h0,        32'hABFF7F01, 0, "lw_10_after_sb");
        add(0, SZ_H, 0, 16'h0011, 32'h0,        32'h0,        1, "lh_11_misal");
        add(1, SZ_W, 0, 16'h0020, 32'h12345678, 32'h0,        0, "sw_20");
        add(1, SZ_W, 0, 16'h0022, 32'hDEADBEEF, 32'h0,        1, "sw_22_misal");
        add(1, SZ_H, 0, 16'h0023, 32'h0000BEEF, 32'h0,        1, "sh_23_misal");
        add(0, SZ_W, 0, 16'h0020, 32'h0,        32'h12345678, 0, "lw_20_kept");
        add(0, SZ_W, 0, 16'h0200, 32'h0,        32'h0,        1, "lw_200_range");
        add(1, SZ_W, 0, 16'h0200, 32'hFFFFFFFF, 32'h0,        1, "sw_200_range");
        add(0, SZ_W, 0, 16'h0000, 32'h0,        32'h0,        0, "lw_0_no_alias");
        add(0, SZ_W, 0, 16'h8010, 32'h0,        32'h0,        1, "lw_high_addr");
        add(0, SZ_D, 0, 16'h0020, 32'h0,        32'h0,        1, "ld_size3");
        add(1, SZ_D, 0, 16'h0020, 32'hFFFFFFFF, 32'h0,        1, "sd_size3");
        add(0, SZ_W, 0, 16'h0020, 32'h0,        32'h12345678, 0, "lw_20_after_sd");
        add(1, SZ_W, 0, 16'h01FC, 32'hCAFEF00D, 32'h0,        0, "sw_last");
        add(0, SZ_H, 1, 16'h01FE, 32'h0,        32'h0000CAFE, 0, "lhu_last");
        add(0, SZ_W, 0, 16'h01FC, 32'h0,        32'hCAFEF00D, 0, "lw_last");

        // Reset values and the clearing walk.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {62'd0, ready1, ready0}, 64'd0);
        check("rst_valid", {62'd0, valid1, valid0}, 64'd0);
        check("rst_err",   {62'd0, err1, err0}, 64'd0);
        check("rst_rdata", {rdata1, rdata0}, 64'd0);
        rst = 1'b0;
        wait_init("init");

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].name);
        end

        // Back-to-back SW/LW stream to one word, one request per cycle.
        sdat = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_we = (c % 2 == 0); req_size = SZ_W;
                req_unsigned = 1'b0; req_addr = 16'h0040; req_wdata = sdat[c/2];
                check("stream_ready", {62'd0, ready1, ready0}, 64'd3);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            obs_v0[c] = valid0; obs_d0[c] = rdata0;
            obs_v1[c] = valid1; obs_d1[c] = rdata1;
        end
        for (int j = 0; j < 10; j++) begin
            logic [31:0] exp0, exp1;
            exp0 = (j < 8 && j % 2 == 1) ? sdat[j/2] : 32'h0;
            exp1 = (j >= 1 && j <= 8 && (j - 1) % 2 == 1) ? sdat[(j-1)/2] : 32'h0;
            check($sformatf("stream_v0_%0d", j), 64'(obs_v0[j]), (j < 8) ? 64'd1 : 64'd0);
            check($sformatf("stream_d0_%0d", j), 64'(obs_d0[j]), 64'(exp0));
            check($sformatf("stream_v1_%0d", j), 64'(obs_v1[j]), (j >= 1 && j <= 8) ? 64'd1 : 64'd0);
            check($sformatf("stream_d1_%0d", j), 64'(obs_d1[j]), 64'(exp1));
        end

        // Reset with the latency-2 response still in flight.
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 16'h0040;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_valid", {62'd0, valid1, valid0}, 64'd0);
        check("midrst_rdata", {rdata1, rdata0}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init("reinit");
        for (int w = 0; w < 128; w++) begin
            do_req(1'b0, SZ_W, 1'b0, 16'(w * 4), 32'h0, 32'h0, 1'b0, $sformatf("clr_%0d", w));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
